// File: rtl/mips_debug_frame_sender_pkg.sv
// Shared constants for the MIPS-side debug frame path.
// Holds the request-select codes and the frame width, so that the
// MicroBlaze-side interface and this sender decode the same values.
// Also holds the sender FSM state type and the source-kind type.
package mips_debug_frame_sender_pkg;

  localparam int DEBUG_NB_FRAME  = 32;
  localparam int DEBUG_NB_SELECT = 6;

  // Request-select codes. 0 means idle, 0x01..0x1F address a register.
  localparam logic [5:0] SEL_IDLE        = 6'h00;
  localparam logic [5:0] SEL_REG_LAST    = 6'h1F;
  localparam logic [5:0] SEL_MEM_DATA    = 6'h20;
  localparam logic [5:0] SEL_MEM_INSTR   = 6'h21;
  localparam logic [5:0] SEL_PC          = 6'h22;
  localparam logic [5:0] SEL_FETCH_DATA  = 6'h24;
  localparam logic [5:0] SEL_FETCH_CTRL  = 6'h25;
  localparam logic [5:0] SEL_DECO_DATA   = 6'h26;
  localparam logic [5:0] SEL_DECO_CTRL   = 6'h27;
  localparam logic [5:0] SEL_EXEC_DATA   = 6'h28;
  localparam logic [5:0] SEL_EXEC_CTRL   = 6'h29;
  localparam logic [5:0] SEL_MEM_L_DATA  = 6'h2A;
  localparam logic [5:0] SEL_MEM_L_CTRL  = 6'h2B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Where the frames of the current burst come from.
  typedef enum logic [1:0] {
    SRC_BUFFER    = 2'd0,
    SRC_MEM_DATA  = 2'd1,
    SRC_MEM_INSTR = 2'd2
  } src_kind_t;

  function automatic logic is_reg_select(input logic [5:0] sel);
    return (sel != SEL_IDLE) && (sel <= SEL_REG_LAST);
  endfunction

endpackage

// File: rtl/mips_debug_frame_sender_if.sv
// Frame bus from the MIPS debug sender to the MicroBlaze debug interface.
// Handshake: there is no back-pressure. Every cycle with frame_valid = 1
// carries one frame that the receiver must take; eod marks the last frame
// of a burst in the same cycle; busy is high for the whole burst; frame is
// zero whenever frame_valid is low.
//   master: sender drives frame, frame_valid, eod, busy
//   slave : receiver observes them
interface mips_debug_frame_sender_if
  import mips_debug_frame_sender_pkg::*;
#(
  parameter int NB_FRAME = DEBUG_NB_FRAME
);
  logic [NB_FRAME-1:0] frame;
  logic                frame_valid;
  logic                eod;
  logic                busy;

  modport master (output frame, frame_valid, eod, busy);
  modport slave  (input  frame, frame_valid, eod, busy);
endinterface

// File: rtl/mips_debug_frame_sender_shifter.sv
// debug_frame_shifter: loadable MSB-first shift buffer.
// Loads NB_DATA bits plus a "frames left" count; each shift moves the buffer
// left by one frame and counts down. o_word is always the top frame of the
// buffer, o_last is high while the count is zero.
// Ports:
//   i_clock, i_reset  clock, synchronous active-high reset
//   i_load            load i_load_data / i_load_count (wins over i_shift)
//   i_shift           advance one frame
//   o_word            top NB_FRAME bits of the buffer
//   o_last            frames-left counter is zero
module debug_frame_shifter #(
  parameter int NB_DATA  = 96,
  parameter int NB_FRAME = 32,
  localparam int NB_COUNT = $clog2(NB_DATA / NB_FRAME) + 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [NB_DATA-1:0]  i_load_data,
  input  logic [NB_COUNT-1:0] i_load_count,
  input  logic                i_shift,
  output logic [NB_FRAME-1:0] o_word,
  output logic                o_last
);

  logic [NB_DATA-1:0]  buffer_q;
  logic [NB_COUNT-1:0] frames_left_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      buffer_q      <= '0;
      frames_left_q <= '0;
    end else if (i_load) begin
      buffer_q      <= i_load_data;
      frames_left_q <= i_load_count;
    end else if (i_shift) begin
      buffer_q <= buffer_q << NB_FRAME;
      // Only loaded from IDLE, so the counter never needs to wrap.
      if (frames_left_q != '0) begin
        frames_left_q <= frames_left_q - 1'b1;
      end
    end
  end

  assign o_word = buffer_q[NB_DATA-1 -: NB_FRAME];
  assign o_last = (frames_left_q == '0);

endmodule

// File: rtl/mips_debug_frame_sender.sv
// mips_debug_frame_sender: MIPS-side responder of the debug data path.
// A one-cycle nonzero i_request_select snapshots the selected source and
// streams it as 32-bit frames on frame_bus, starting the next cycle, with
// eod on the last frame. Selects arriving during a burst are dropped.
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_request_select        request code (0 = idle)
//   o_reg_addr              register-file debug address = select[4:0]
//   i_reg_data, i_pc        register-file data, PC
//   i_mem_data              data-memory read data (valid at T+1)
//   i_instr_mem_data        instruction-memory read data (valid at T+1)
//   i_*_data / i_*_ctrl     pipeline latch bundles (fetch/deco/exec/mem)
//   frame_bus               frame, frame_valid, eod, busy
//   o_debug_state           current FSM state
module mips_debug_frame_sender
  import mips_debug_frame_sender_pkg::*;
#(
  parameter int NB_FRAME      = DEBUG_NB_FRAME,
  parameter int NB_LATCH_DATA = 96,
  parameter int NB_LATCH_CTRL = 32,
  parameter int NB_SELECT     = DEBUG_NB_SELECT,
  parameter int NB_PC         = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_SELECT-1:0]     i_request_select,
  output logic [4:0]               o_reg_addr,
  input  logic [31:0]              i_reg_data,
  input  logic [NB_PC-1:0]         i_pc,
  input  logic [31:0]              i_mem_data,
  input  logic [31:0]              i_instr_mem_data,
  input  logic [NB_LATCH_DATA-1:0] i_fetch_data,
  input  logic [NB_LATCH_DATA-1:0] i_deco_data,
  input  logic [NB_LATCH_DATA-1:0] i_exec_data,
  input  logic [NB_LATCH_DATA-1:0] i_mem_latch_data,
  input  logic [NB_LATCH_CTRL-1:0] i_fetch_ctrl,
  input  logic [NB_LATCH_CTRL-1:0] i_deco_ctrl,
  input  logic [NB_LATCH_CTRL-1:0] i_exec_ctrl,
  input  logic [NB_LATCH_CTRL-1:0] i_mem_latch_ctrl,
  mips_debug_frame_sender_if.master frame_bus,
  output state_t                   o_debug_state
);

  localparam int NB_COUNT     = $clog2(NB_LATCH_DATA / NB_FRAME) + 1;
  localparam int N_DATA_FRAME = NB_LATCH_DATA / NB_FRAME;

  state_t    state_q;
  src_kind_t kind_q;

  logic                     request;
  logic [NB_FRAME-1:0]      snap_word;
  logic [NB_LATCH_DATA-1:0] snap_buf;
  logic [NB_COUNT-1:0]      snap_count;
  logic                     snap_is_bundle;
  src_kind_t                snap_kind;
  logic                     load;
  logic                     shift;
  logic [NB_FRAME-1:0]      shift_word;
  logic                     shift_last;

  // Register file is addressed straight from the select so its data is
  // already valid in the request cycle.
  assign o_reg_addr = i_request_select[4:0];
  assign request    = (i_request_select != '0);

  // Build what gets loaded into the buffer. Single-frame sources are placed
  // in the top frame slot so the first (and only) frame out is that word.
  // Unknown codes fall through with an all-zero word.
  always_comb begin
    snap_word      = '0;
    snap_buf       = '0;
    snap_count     = '0;
    snap_is_bundle = 1'b0;
    snap_kind      = SRC_BUFFER;
    if (is_reg_select(i_request_select)) begin
      snap_word = NB_FRAME'(i_reg_data);
    end else begin
      case (i_request_select)
        SEL_MEM_DATA:   snap_kind = SRC_MEM_DATA;
        SEL_MEM_INSTR:  snap_kind = SRC_MEM_INSTR;
        SEL_PC:         snap_word = NB_FRAME'(i_pc);
        SEL_FETCH_DATA: begin snap_buf = i_fetch_data;     snap_is_bundle = 1'b1; end
        SEL_DECO_DATA:  begin snap_buf = i_deco_data;      snap_is_bundle = 1'b1; end
        SEL_EXEC_DATA:  begin snap_buf = i_exec_data;      snap_is_bundle = 1'b1; end
        SEL_MEM_L_DATA: begin snap_buf = i_mem_latch_data; snap_is_bundle = 1'b1; end
        SEL_FETCH_CTRL: snap_word = NB_FRAME'(i_fetch_ctrl);
        SEL_DECO_CTRL:  snap_word = NB_FRAME'(i_deco_ctrl);
        SEL_EXEC_CTRL:  snap_word = NB_FRAME'(i_exec_ctrl);
        SEL_MEM_L_CTRL: snap_word = NB_FRAME'(i_mem_latch_ctrl);
        default:        snap_word = '0;
      endcase
    end
    if (snap_is_bundle) begin
      snap_count = NB_COUNT'(N_DATA_FRAME - 1);
    end else begin
      snap_buf[NB_LATCH_DATA-1 -: NB_FRAME] = snap_word;
    end
  end

  // Requests are only accepted in IDLE; in SEND (including the eod cycle)
  // they are simply not looked at.
  assign load  = (state_q == ST_IDLE) && request;
  assign shift = (state_q == ST_SEND);

  debug_frame_shifter #(
    .NB_DATA  (NB_LATCH_DATA),
    .NB_FRAME (NB_FRAME)
  ) u_shifter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (load),
    .i_load_data  (snap_buf),
    .i_load_count (snap_count),
    .i_shift      (shift),
    .o_word       (shift_word),
    .o_last       (shift_last)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      kind_q  <= SRC_BUFFER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (request) begin
            state_q <= ST_SEND;
            kind_q  <= snap_kind;
          end
        end
        ST_SEND: begin
          if (shift_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, except the memory sources whose
  // read data arrives in the first SEND cycle and is passed straight out.
  always_comb begin
    frame_bus.frame = '0;
    if (state_q == ST_SEND) begin
      case (kind_q)
        SRC_MEM_DATA:  frame_bus.frame = NB_FRAME'(i_mem_data);
        SRC_MEM_INSTR: frame_bus.frame = NB_FRAME'(i_instr_mem_data);
        default:       frame_bus.frame = shift_word;
      endcase
    end
  end

  assign frame_bus.frame_valid = (state_q == ST_SEND);
  assign frame_bus.busy        = (state_q == ST_SEND);
  assign frame_bus.eod         = (state_q == ST_SEND) && shift_last;
  assign o_debug_state         = state_q;

endmodule

// File: tb/tb_mips_debug_frame_sender.sv
// Bench for mips_debug_frame_sender: directed requests from the test plan
// followed by random requests, each compared against a frame list computed
// from the select-code rules.
module tb_mips_debug_frame_sender;
  import mips_debug_frame_sender_pkg::*;

  localparam int NB_LATCH_DATA = 96;
  localparam int NB_LATCH_CTRL = 32;

  // ---------------- clock / reset ----------------
  logic i_clock;
  logic i_reset;
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // ---------------- DUT signals ----------------
  logic [5:0]               i_request_select;
  logic [4:0]               o_reg_addr;
  logic [31:0]              reg_data;
  logic [31:0]              pc;
  logic [31:0]              i_mem_data;
  logic [31:0]              i_instr_mem_data;
  logic [NB_LATCH_DATA-1:0] ldata [4];
  logic [NB_LATCH_CTRL-1:0] lctrl [4];
  state_t                   dbg_state;

  mips_debug_frame_sender_if #(.NB_FRAME(32)) frame_bus ();

  mips_debug_frame_sender dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_request_select (i_request_select),
    .o_reg_addr       (o_reg_addr),
    .i_reg_data       (reg_data),
    .i_pc             (pc),
    .i_mem_data       (i_mem_data),
    .i_instr_mem_data (i_instr_mem_data),
    .i_fetch_data     (ldata[0]),
    .i_deco_data      (ldata[1]),
    .i_exec_data      (ldata[2]),
    .i_mem_latch_data (ldata[3]),
    .i_fetch_ctrl     (lctrl[0]),
    .i_deco_ctrl      (lctrl[1]),
    .i_exec_ctrl      (lctrl[2]),
    .i_mem_latch_ctrl (lctrl[3]),
    .frame_bus        (frame_bus),
    .o_debug_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mem_next;
  logic [31:0] imem_next;
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of frames a request produces, from the select rules.
  function automatic void model(input logic [5:0] code);
    int c;
    int g;
    c = int'(code);
    exp_q.delete();
    if (c >= 1 && c <= 31) begin
      exp_q.push_back(reg_data);
    end else if (c == 32) begin
      exp_q.push_back(mem_next);
    end else if (c == 33) begin
      exp_q.push_back(imem_next);
    end else if (c == 34) begin
      exp_q.push_back(pc);
    end else if (c >= 36 && c <= 43) begin
      g = (c - 36) / 2;
      if ((c % 2) == 0) begin
        for (int w = NB_LATCH_DATA / 32 - 1; w >= 0; w--) begin
          exp_q.push_back(ldata[g][w*32 +: 32]);
        end
      end else begin
        exp_q.push_back(32'(lctrl[g]));
      end
    end else begin
      exp_q.push_back(32'h0);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble();
    reg_data = $urandom;
    pc       = $urandom;
    for (int i = 0; i < 4; i++) begin
      ldata[i] = {$urandom, $urandom, $urandom};
      lctrl[i] = $urandom;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, frame_bus.frame_valid, 1'b0);
    check({tag, "_busy"},  frame_bus.busy,        1'b0);
    check({tag, "_eod"},   frame_bus.eod,         1'b0);
    check({tag, "_frame"}, frame_bus.frame,       32'h0);
  endtask

  // Called #1 after a posedge with the DUT idle. Issues a one-cycle request,
  // optionally pokes another select during frame inject_at, and checks each
  // frame plus the idle cycle after the burst.
  task automatic run_request(input logic [5:0] code, input int inject_at,
                             input logic [5:0] inject_code);
    int n;
    model(code);
    n = exp_q.size();
    i_mem_data       = ~mem_next;
    i_instr_mem_data = ~imem_next;
    i_request_select = code;
    @(negedge i_clock);
    check("reg_addr", o_reg_addr, code[4:0]);
    check("busy_at_T", frame_bus.busy, 1'b0);
    @(posedge i_clock); #1;
    i_request_select = '0;
    i_mem_data       = mem_next;
    i_instr_mem_data = imem_next;
    scramble();
    for (int k = 0; k < n; k++) begin
      if (k == inject_at) i_request_select = inject_code;
      @(negedge i_clock);
      check("valid", frame_bus.frame_valid, 1'b1);
      check("frame", frame_bus.frame,       exp_q[k]);
      check("eod",   frame_bus.eod,         (k == n - 1));
      check("busy",  frame_bus.busy,        1'b1);
      @(posedge i_clock); #1;
      i_request_select = '0;
      scramble();
    end
    @(negedge i_clock);
    check_idle("after_burst");
    @(posedge i_clock); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    i_reset          = 1'b1;
    i_request_select = '0;
    mem_next         = 32'h0;
    imem_next        = 32'h0;
    i_mem_data       = 32'h0;
    i_instr_mem_data = 32'h0;
    scramble();
    repeat (3) @(posedge i_clock);
    #1 i_reset = 1'b0;

    // Reset state, then idle for five cycles.
    repeat (5) @(posedge i_clock);
    #1;
    @(negedge i_clock);
    check_idle("reset");
    check("reset_state", dbg_state, ST_IDLE);
    @(posedge i_clock); #1;

    // Register 5.
    reg_data = 32'hDEADBEEF;
    run_request(6'h05, -1, 6'h00);

    // Decode data bundle; inputs scramble at T+1, snapshot must hold.
    ldata[1] = 96'h111111112222222233333333;
    run_request(6'h26, -1, 6'h00);

    // Data memory read data presented only at T+1.
    mem_next = 32'hCAFE0001;
    run_request(6'h20, -1, 6'h00);

    // Instruction memory.
    imem_next = 32'h0BAD_F00D;
    run_request(6'h21, -1, 6'h00);

    // Exec data with a PC request at T+2: ignored, no PC frame follows.
    run_request(6'h28, 1, 6'h22);

    // Select in the eod cycle is ignored.
    run_request(6'h24, 2, 6'h05);

    // PC and a ctrl bundle.
    pc = 32'h0040_0010;
    run_request(6'h22, -1, 6'h00);
    lctrl[3] = 32'hA5A5_0003;
    run_request(6'h2B, -1, 6'h00);

    // Unmapped code -> one zero frame.
    run_request(6'h3F, -1, 6'h00);
    run_request(6'h23, -1, 6'h00);

    // Mem latch data burst cut by reset during T+2.
    model(6'h2A);
    i_request_select = 6'h2A;
    @(posedge i_clock); #1;
    i_request_select = '0;
    scramble();
    @(negedge i_clock);
    check("rst_f0_frame", frame_bus.frame, exp_q[0]);
    check("rst_f0_eod",   frame_bus.eod,   1'b0);
    @(posedge i_clock); #1;
    @(negedge i_clock);
    check("rst_f1_frame", frame_bus.frame, exp_q[1]);
    check("rst_f1_eod",   frame_bus.eod,   1'b0);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    check_idle("rst_T3");
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clock); #1;
      @(negedge i_clock);
      check("rst_no_eod", frame_bus.eod, 1'b0);
    end
    @(posedge i_clock); #1;

    // Random requests with occasional stray selects during the burst.
    for (int r = 0; r < 40; r++) begin
      logic [5:0] code;
      logic [5:0] inj;
      code      = 6'($urandom_range(1, 63));
      inj       = 6'($urandom_range(1, 63));
      mem_next  = $urandom;
      imem_next = $urandom;
      scramble();
      run_request(code, int'($urandom_range(0, 4)) - 1, inj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_debug_frame_sender.md
Name: mips_debug_frame_sender

Overview:
- MIPS-side responder of the debug data path: turns a one-cycle request-select pulse from the MicroBlaze interface into a burst of 32-bit frames on i_frame_from_mips, flagging the last with i_eod.
- Sources: register file, PC, data memory, instruction memory, and the four pipeline latch groups (data and ctrl halves).
- Snapshots the selected source at request time, so a multi-frame burst is coherent even if the pipeline advances.

Parameters:
- NB_FRAME, 32, frame width.
- NB_LATCH_DATA, 96, width of each latch data bundle; must be a multiple of NB_FRAME.
- NB_LATCH_CTRL, 32, width of each latch ctrl bundle; must be <= NB_FRAME.
- NB_SELECT, 6, request-select width.
- NB_PC, 32, PC width.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_request_select  in  NB_SELECT  request code, nonzero for exactly one cycle per request; 0 = idle
- o_reg_addr  out  5  register-file debug read address = i_request_select[4:0], combinational
- i_reg_data  in  32  async register-file read data
- i_pc  in  NB_PC  current PC
- i_mem_data  in  32  data-memory read data, valid 1 cycle after the request (address is driven elsewhere)
- i_instr_mem_data  in  32  instruction-memory read data, valid 1 cycle after the request
- i_fetch_data, i_deco_data, i_exec_data, i_mem_latch_data  in  NB_LATCH_DATA each  latch data bundles
- i_fetch_ctrl, i_deco_ctrl, i_exec_ctrl, i_mem_latch_ctrl  in  NB_LATCH_CTRL each  latch ctrl bundles
- o_frame  out  NB_FRAME  frame to the interface (its i_frame_from_mips)
- o_frame_valid  out  1  o_frame carries a burst frame
- o_eod  out  1  last frame of the burst; high in the same cycle as that frame
- o_busy  out  1  burst in progress

Behaviour:
- Select decode:
  - 0x01–0x1F: register n, 1 frame.
  - 0x20: data memory, 1 frame.
  - 0x21: instruction memory, 1 frame.
  - 0x22: PC, 1 frame, zero-extended/truncated to NB_FRAME.
  - 0x24 / 0x25: fetch data / ctrl.
  - 0x26 / 0x27: decode data / ctrl.
  - 0x28 / 0x29: exec data / ctrl.
  - 0x2A / 0x2B: mem data / ctrl.
  - Data bundles send NB_LATCH_DATA/NB_FRAME frames (3 by default), MSB word first. Ctrl bundles send 1 frame, zero-extended.
  - Any other nonzero code: 1 frame of all zeros with o_eod.
  - Register 0 is not requestable, because 0 means idle.
- FSM has two states, IDLE and SEND:
  - IDLE → SEND on a nonzero select at cycle T.
  - On that same edge: snapshot the selected source (reg/PC/latch) into the NB_LATCH_DATA shift buffer, store the source kind, set frames_left = N−1.
  - SEND: cycle T+1 drives the first frame. This fixed 1-cycle latency matches the interface, whose capture enable rises at T+1.
  - Memory sources (0x20/0x21) are not snapshotted; o_frame = i_mem_data / i_instr_mem_data passes through combinationally in cycle T+1.
  - Each SEND cycle: o_frame = top NB_FRAME bits of the buffer, o_frame_valid = 1. The buffer shifts left by NB_FRAME; frames_left decrements.
  - o_eod = 1 when frames_left == 0. SEND → IDLE on that edge.
  - Consequences: 1-frame burst = exactly 1 SEND cycle; 3-frame burst = cycles T+1..T+3 with o_eod at T+3.
- A nonzero select while in SEND is ignored. No queueing; o_busy stays high; the current burst is unaffected.
- A select arriving in the same cycle as o_eod is also ignored.
- o_frame is 0 whenever o_frame_valid = 0.
- Reset at any point, including mid-burst, forces IDLE, buffer = 0, frames_left = 0.
- Reset values of all outputs except o_reg_addr: o_frame = 0, o_frame_valid = 0, o_eod = 0, o_busy = 0.
- o_reg_addr is not reset; it follows i_request_select[4:0] at all times.
- frames_left is sized $clog2(NB_LATCH_DATA/NB_FRAME)+1 bits; it never wraps because it is only loaded in IDLE.

Decomposition:
- Shared package holds the select codes (REG range, MEM_DATA, MEM_INSTR, PC, the eight latch codes) and the NB_FRAME constant, so the interface and this sender use identical values.
- One natural sub-module: debug_frame_shifter, a loadable NB_LATCH_DATA → NB_FRAME MSB-first shift buffer with a frames_left counter and last flag.

Test Plan:
- Reset, then idle 5 cycles → o_frame = 0, o_frame_valid = 0, o_eod = 0, o_busy = 0.
- Select 0x05 pulse at T with i_reg_data = 0xDEADBEEF → o_reg_addr = 5 at T; at T+1 o_frame = 0xDEADBEEF, o_frame_valid = 1, o_eod = 1; idle at T+2.
- Select 0x26 with i_deco_data = 0x111111112222222233333333, then the input changed at T+1 → frames 0x11111111, 0x22222222, 0x33333333 at T+1..T+3; o_eod only at T+3 (snapshot held).
- Select 0x20 with i_mem_data = 0xCAFE0001 presented at T+1 → o_frame = 0xCAFE0001 with o_eod at T+1.
- Select 0x28 then select 0x22 at T+2 → the 0x22 request is ignored; 3 exec frames are sent; o_busy falls after T+3; no PC frame follows.
- Select 0x3F → one zero frame with o_eod at T+1. Separately, select 0x2A then i_reset at T+2 → at T+3 o_frame_valid = 0, o_busy = 0, and no o_eod is ever seen.
